// File: rtl/usb_fifo_writer.sv
// usb_fifo_writer: fabric-to-host byte transmitter for the EZ-USB FX2
// synchronous slave-FIFO interface (IN endpoint on FD[7:0]).
// Bytes are accepted on a valid/ready port into a small RAM FIFO. Each byte
// is strobed into the FX2 with SLWR# while FULL# permits. A partial packet is
// committed with PKTEND# after an idle timeout.
// Optional build macro: USB_FIFO_WRITER_ZLP_EN. When it is defined, a packet
// that ends exactly on a 512-byte boundary is followed by a zero-length
// packet once the idle timer expires.
module usb_fifo_writer #(
  parameter int          DEPTH_LOG2  = 4,
  parameter int          PKT_TIMEOUT = 1024,
  parameter logic [1:0]  EP_ADDR     = 2'b10
) (
  input  logic                  USB_CLKO,
  input  logic                  USB_RESET2,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [7:0]            usb_fd,
  output logic                  usb_fd_oe,
  output logic                  usb_slwr_n,
  output logic                  usb_slrd_n,
  output logic                  usb_sloe_n,
  output logic                  usb_pktend_n,
  output logic [1:0]            usb_fifoadr,
  input  logic                  usb_full_n
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [15:0]         TIMER_LAST = 16'(PKT_TIMEOUT - 1);
  localparam logic [8:0]          PKT_LAST   = 9'd511;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    PKTEND = 2'd2
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]            mem [DEPTH];
  logic [7:0]            ram_q_reg;
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  fresh_reg;
  logic                  s_ready_reg;

  // Transmit control
  state_t                state_reg;
  logic [8:0]            pkt_cnt_reg;
  logic [15:0]           timer_reg;
  logic [7:0]            fd_reg;
  logic                  fd_oe_reg;
  logic                  slwr_n_reg;
  logic                  pktend_n_reg;
  logic                  slrd_n_reg;
  logic                  sloe_n_reg;
  logic [1:0]            fifoadr_reg;

  logic                  push;
  logic                  pop;
  logic                  can_pop;
  logic                  timer_armed;
  logic                  timer_run;

`ifdef USB_FIFO_WRITER_ZLP_EN
  logic                  zlp_flag_reg;
`endif

  assign push = s_valid & s_ready_reg;

  // The RAM read is registered, so a byte written on one edge is not
  // readable on the next; fresh_reg marks a head entry that is not yet
  // visible on ram_q_reg.
  assign can_pop = (count_reg != '0) && !fresh_reg;

`ifdef USB_FIFO_WRITER_ZLP_EN
  assign timer_armed = (pkt_cnt_reg != 9'd0) || zlp_flag_reg;
`else
  assign timer_armed = (pkt_cnt_reg != 9'd0);
`endif

  assign timer_run = (state_reg == IDLE) && (count_reg == '0) && timer_armed;

  // Pop decision, next fill level and the RAM read address for the next head
  always_comb begin
    pop        = 1'b0;
    count_next = count_reg;
    rd_addr    = rd_ptr_reg;
    if (!USB_RESET2 && (state_reg != PKTEND) && can_pop && usb_full_n) begin
      pop = 1'b1;
    end
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
    if (pop) begin
      rd_addr = rd_ptr_reg + 1'b1;
    end
  end

  // Byte storage: write on push, registered read of the (next) head entry
  always_ff @(posedge USB_CLKO) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_data;
    end
    ram_q_reg <= mem[rd_addr];
  end

  // FIFO pointers, level and input-side ready
  always_ff @(posedge USB_CLKO) begin
    if (USB_RESET2) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      fresh_reg   <= 1'b0;
      s_ready_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg   <= count_next;
      fresh_reg   <= push && (count_next == {{DEPTH_LOG2{1'b0}}, 1'b1});
      s_ready_reg <= (count_next != FULL_LEVEL);
    end
  end

  // Transmit FSM: SLWR# strobes, packet byte count, idle timer and PKTEND#
  always_ff @(posedge USB_CLKO) begin
    if (USB_RESET2) begin
      state_reg    <= IDLE;
      pkt_cnt_reg  <= 9'd0;
      timer_reg    <= 16'd0;
      fd_reg       <= 8'h00;
      fd_oe_reg    <= 1'b0;
      slwr_n_reg   <= 1'b1;
      pktend_n_reg <= 1'b1;
`ifdef USB_FIFO_WRITER_ZLP_EN
      zlp_flag_reg <= 1'b0;
`endif
    end else begin
      fd_oe_reg    <= 1'b1;
      pktend_n_reg <= 1'b1;
      case (state_reg)
        IDLE, WRITE: begin
          if (pop) begin
            fd_reg      <= ram_q_reg;
            slwr_n_reg  <= 1'b0;
            pkt_cnt_reg <= pkt_cnt_reg + 9'd1;
            timer_reg   <= 16'd0;
            state_reg   <= WRITE;
`ifdef USB_FIFO_WRITER_ZLP_EN
            // Only the byte that completes a 512-byte packet arms the ZLP.
            zlp_flag_reg <= (pkt_cnt_reg == PKT_LAST);
`endif
          end else begin
            slwr_n_reg <= 1'b1;
            state_reg  <= IDLE;
            if (push) begin
              // New data is on its way: cancel any pending commit.
              timer_reg <= 16'd0;
            end else if (timer_run) begin
              if (timer_reg == TIMER_LAST) begin
                // Hold at the limit until the FX2 has room for the commit.
                if (usb_full_n) begin
                  pktend_n_reg <= 1'b0;
                  state_reg    <= PKTEND;
                end
              end else begin
                timer_reg <= timer_reg + 16'd1;
              end
            end
          end
        end
        PKTEND: begin
          slwr_n_reg  <= 1'b1;
          pkt_cnt_reg <= 9'd0;
          timer_reg   <= 16'd0;
          state_reg   <= IDLE;
`ifdef USB_FIFO_WRITER_ZLP_EN
          zlp_flag_reg <= 1'b0;
`endif
        end
        default: begin
          slwr_n_reg <= 1'b1;
          state_reg  <= IDLE;
        end
      endcase
    end
  end

  // Static FX2 control lines: read side unused, endpoint address fixed
  always_ff @(posedge USB_CLKO) begin
    if (USB_RESET2) begin
      slrd_n_reg  <= 1'b1;
      sloe_n_reg  <= 1'b1;
      fifoadr_reg <= EP_ADDR;
    end else begin
      slrd_n_reg  <= 1'b1;
      sloe_n_reg  <= 1'b1;
      fifoadr_reg <= EP_ADDR;
    end
  end

  assign s_ready      = s_ready_reg;
  assign level        = count_reg;
  assign usb_fd       = fd_reg;
  assign usb_fd_oe    = fd_oe_reg;
  assign usb_slwr_n   = slwr_n_reg;
  assign usb_pktend_n = pktend_n_reg;
  assign usb_slrd_n   = slrd_n_reg;
  assign usb_sloe_n   = sloe_n_reg;
  assign usb_fifoadr  = fifoadr_reg;

endmodule

// File: tb/tb_usb_fifo_writer.sv
// Testbench for usb_fifo_writer (default parameters, PKT_TIMEOUT = 1024).
// Honours USB_FIFO_WRITER_ZLP_EN for the packet-wrap expectation.
module tb_usb_fifo_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [4:0] level;
  logic [7:0] usb_fd;
  logic       usb_fd_oe;
  logic       usb_slwr_n;
  logic       usb_slrd_n;
  logic       usb_sloe_n;
  logic       usb_pktend_n;
  logic [1:0] usb_fifoadr;
  logic       usb_full_n;

  always #5 clk = ~clk;

  usb_fifo_writer dut (
    .USB_CLKO     (clk),
    .USB_RESET2   (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .level        (level),
    .usb_fd       (usb_fd),
    .usb_fd_oe    (usb_fd_oe),
    .usb_slwr_n   (usb_slwr_n),
    .usb_slrd_n   (usb_slrd_n),
    .usb_sloe_n   (usb_sloe_n),
    .usb_pktend_n (usb_pktend_n),
    .usb_fifoadr  (usb_fifoadr),
    .usb_full_n   (usb_full_n)
  );

  int tests = 0;
  int fails = 0;

  // Edge counter: after rising edge n, cyc == n
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FULL# value the DUT saw at the most recent rising edge
  logic full_at_edge = 1'b1;
  always @(posedge clk) full_at_edge <= usb_full_n;

  // Bus monitor, sampled mid-cycle
  logic [7:0] wr_log[$];
  int         wr_cyc_log[$];
  int         wr_cnt = 0;
  int         pk_cnt = 0;
  int         last_wr_cyc = 0;
  int         pk_cyc = 0;
  int         viol = 0;

  always @(negedge clk) begin
    int v;
    v = 0;
    if (!usb_slwr_n) begin
      wr_log.push_back(usb_fd);
      wr_cyc_log.push_back(cyc);
      wr_cnt      <= wr_cnt + 1;
      last_wr_cyc <= cyc;
      if (!full_at_edge) v = v + 1;
    end
    if (!usb_pktend_n) begin
      pk_cnt <= pk_cnt + 1;
      pk_cyc <= cyc;
    end
    if (!usb_slwr_n && !usb_pktend_n) v = v + 1;
    if (v != 0) viol <= viol + v;
  end

  int push0_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  task automatic do_reset(input int n);
    rst     = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    repeat (n) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_bytes(input int n, input logic [7:0] base);
    logic [7:0] d;
    int w;
    d = base;
    for (int i = 0; i < n; i++) begin
      s_data  = d;
      s_valid = 1'b1;
      w = 0;
      while (!s_ready && w < 500) begin
        tick();
        w++;
      end
      if (w >= 500) begin
        bound_fail("push_wait");
        break;
      end
      tick();
      if (i == 0) push0_cyc = cyc;
      d = d + 8'd1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_writes(input int target, input int bound, input string name);
    int k;
    k = 0;
    while (wr_cnt < target && k < bound) begin
      tick();
      k++;
    end
    if (wr_cnt < target) bound_fail(name);
  endtask

  task automatic order_errors(input int start, input int n, input logic [7:0] base,
                              output int errs);
    logic [7:0] d;
    d = base;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if (start + i >= wr_log.size()) errs++;
      else if (wr_log[start + i] != d) errs++;
      d = d + 8'd1;
    end
  endtask

  task automatic stall_thread(input int wr_base, input int after, input int len);
    int k;
    if (len > 0) begin
      k = 0;
      while (wr_cnt < wr_base + after && k < 200) begin
        tick();
        k++;
      end
      if (wr_cnt < wr_base + after) bound_fail("stall_wait");
      usb_full_n = 1'b0;
      repeat (len) tick();
      usb_full_n = 1'b1;
    end
  endtask

  typedef struct {
    int         nbytes;
    logic [7:0] base;
    int         stall_after;
    int         stall_len;
    int         exp_writes;
    int         exp_pktend;
    int         exp_first_lat;
    int         exp_pk_gap;
  } vec_t;

  initial begin
    vec_t vecs [5];
    int   wb, pb, vb, errs, acc, lw;

    vecs[0] = '{16, 8'h00, 0,  0, 16, 1, 2, 1025};
    vecs[1] = '{ 8, 8'hA0, 3, 10,  8, 1, 2, 1025};
    vecs[2] = '{ 1, 8'h5A, 0,  0,  1, 1, 2, 1025};
    vecs[3] = '{ 5, 8'h30, 1,  3,  5, 1, 2, 1025};
    vecs[4] = '{16, 8'hF0, 8, 20, 16, 1, 2, 1025};

    rst        = 1'b1;
    s_valid    = 1'b0;
    s_data     = 8'h00;
    usb_full_n = 1'b1;

    // ---- Reset and idle ----
    tick();
    check("rst_slwr_n",   usb_slwr_n,   1);
    check("rst_pktend_n", usb_pktend_n, 1);
    check("rst_slrd_n",   usb_slrd_n,   1);
    check("rst_sloe_n",   usb_sloe_n,   1);
    check("rst_fifoadr",  usb_fifoadr,  2);
    check("rst_fd_oe",    usb_fd_oe,    0);
    check("rst_fd",       usb_fd,       0);
    check("rst_s_ready",  s_ready,      0);
    check("rst_level",    level,        0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rel_fd_oe",   usb_fd_oe, 1);
    check("rel_s_ready", s_ready,   1);
    wb = wr_cnt;
    pb = pk_cnt;
    repeat (2000) tick();
    check("idle_writes", wr_cnt - wb, 0);
    check("idle_pktend", pk_cnt - pb, 0);
    check("idle_level",  level,       0);
    $display("[TB] idle: writes=%0d pktend=%0d", wr_cnt - wb, pk_cnt - pb);

    // ---- Table-driven bursts ----
    for (int v = 0; v < 5; v++) begin
      do_reset(2);
      wb = wr_cnt;
      pb = pk_cnt;
      vb = viol;
      fork
        push_bytes(vecs[v].nbytes, vecs[v].base);
        stall_thread(wb, vecs[v].stall_after, vecs[v].stall_len);
      join
      wait_writes(wb + vecs[v].nbytes, 300, "vec_writes_wait");
      repeat (1100) tick();
      check("vec_writes", wr_cnt - wb, vecs[v].exp_writes);
      order_errors(wb, vecs[v].nbytes, vecs[v].base, errs);
      check("vec_order", errs, 0);
      if (wr_cyc_log.size() > wb)
        check("vec_first_lat", wr_cyc_log[wb] - push0_cyc, vecs[v].exp_first_lat);
      check("vec_pktend", pk_cnt - pb, vecs[v].exp_pktend);
      check("vec_pk_gap", pk_cyc - last_wr_cyc, vecs[v].exp_pk_gap);
      check("vec_rules", viol - vb, 0);
      check("vec_level", level, 0);
      $display("[TB] vec %0d: bytes=%0d writes=%0d pktend=%0d pk_gap=%0d",
               v, vecs[v].nbytes, wr_cnt - wb, pk_cnt - pb, pk_cyc - last_wr_cyc);
    end

    // ---- FULL# held low: FIFO fills to 16 and s_ready drops ----
    do_reset(2);
    usb_full_n = 1'b0;
    wb  = wr_cnt;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      s_data  = 8'h40 + 8'(acc);
      s_valid = 1'b1;
      if (s_ready) begin
        tick();
        acc++;
      end else begin
        tick();
      end
    end
    s_valid = 1'b0;
    check("full_accepted", acc,         16);
    check("full_level",    level,       16);
    check("full_s_ready",  s_ready,     0);
    check("full_writes",   wr_cnt - wb, 0);
    usb_full_n = 1'b1;
    wait_writes(wb + 16, 100, "full_drain_wait");
    order_errors(wb, 16, 8'h40, errs);
    check("full_order", errs, 0);
    tick();
    check("full_drained", level, 0);
    $display("[TB] full: accepted=%0d drained=%0d", acc, wr_cnt - wb);

    // ---- Timeout cancelled by a push on the timeout cycle ----
    do_reset(2);
    wb = wr_cnt;
    pb = pk_cnt;
    push_bytes(3, 8'h11);
    wait_writes(wb + 3, 100, "cancel_wait3");
    tick();
    tick();
    lw = last_wr_cyc;
    while (cyc < lw + 1024) tick();
    s_data  = 8'h14;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    tick();
    check("cancel_no_pktend", pk_cnt - pb, 0);
    wait_writes(wb + 4, 20, "cancel_wait4");
    check("cancel_4th_cyc", last_wr_cyc - lw, 1027);
    repeat (1100) tick();
    check("cancel_pktend", pk_cnt - pb, 1);
    check("cancel_pk_gap", pk_cyc - last_wr_cyc, 1025);
    order_errors(wb, 4, 8'h11, errs);
    check("cancel_order", errs, 0);
    $display("[TB] cancel: writes=%0d pktend=%0d", wr_cnt - wb, pk_cnt - pb);

    // ---- Reset in the middle of a burst ----
    do_reset(2);
    usb_full_n = 1'b0;
    push_bytes(12, 8'h60);
    tick();
    check("mid_level12", level, 12);
    usb_full_n = 1'b1;
    tick();
    tick();
    tick();
    check("mid_level9", level,      9);
    check("mid_slwr0",  usb_slwr_n, 0);
    rst = 1'b1;
    tick();
    check("mid_rst_slwr",   usb_slwr_n,   1);
    check("mid_rst_level",  level,        0);
    check("mid_rst_pktend", usb_pktend_n, 1);
    check("mid_rst_ready",  s_ready,      0);
    rst = 1'b0;
    tick();
    wb = wr_cnt;
    pb = pk_cnt;
    repeat (1200) tick();
    check("mid_residual",  wr_cnt - wb, 0);
    check("mid_no_pktend", pk_cnt - pb, 0);
    check("mid_level_end", level,       0);
    $display("[TB] reset-mid: residual writes=%0d", wr_cnt - wb);

    // ---- 512-byte packet wrap ----
    do_reset(2);
    wb = wr_cnt;
    pb = pk_cnt;
    vb = viol;
    push_bytes(512, 8'h00);
    wait_writes(wb + 512, 100, "wrap_wait");
    repeat (1100) tick();
    check("wrap_writes", wr_cnt - wb, 512);
    order_errors(wb, 512, 8'h00, errs);
    check("wrap_order", errs, 0);
    check("wrap_rules", viol - vb, 0);
`ifdef USB_FIFO_WRITER_ZLP_EN
    check("wrap_zlp",    pk_cnt - pb,         1);
    check("wrap_zlp_gap", pk_cyc - last_wr_cyc, 1025);
`else
    check("wrap_no_pktend", pk_cnt - pb, 0);
`endif
    $display("[TB] wrap: writes=%0d pktend=%0d", wr_cnt - wb, pk_cnt - pb);

    check("strobe_rules_total", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
